fpu_div_exp_ctl: RTL and testbench
==================================

Name: fpu_div_exp_ctl

Overview:
- Control sequencer for the divide-pipe exponent datapath.
- Accepts a divide request, walks it through front-end exponent steps: bias, exponent subtract, two normalisation shift adjusts.
- Holds for the fraction iteration window, then runs back-end steps: rebias, conditional decrement, round/overflow. Presents the result with a valid/ack handshake.
- Drives every select, stage strobe and load enable of the exponent datapath, plus its clock enable.

Parameters:
- DBL_ITER, 55, fraction iteration cycles for double.
- SNG_ITER, 26, fraction iteration cycles for single.
- CNT_W, 6, iteration counter width (must hold DBL_ITER-1).

Ports:
- rclk  in  1  global clock
- arst_l  in  1  asynchronous active-low reset
- div_start  in  1  request valid; exponents present on inq buses this cycle
- div_dbl  in  1  1 = double, 0 = single (sampled with div_start)
- div_special_inf  in  1  special case, infinity/NaN exponent result (sampled with div_start)
- div_special_zero  in  1  special case, zero exponent result (sampled with div_start)
- div_q_norm  in  1  quotient MSB set, no exponent decrement (used in S_DEC)
- div_ovf  in  1  exponent overflow detected (used in S_RND)
- div_rndup  in  1  rounding increment required (used in S_RND)
- div_rnd_to_0  in  1  overflow rounds toward zero/max-finite (used in S_RND)
- div_res_ack  in  1  consumer accepts result
- div_busy  out  1  sequencer not in S_IDLE
- div_res_vld  out  1  exponent result valid (S_HOLD)
- d1stg_step  out  1  load exponent input registers
- fdiv_clken_l  out  1  datapath clock enable, active low
- All exponent-datapath controls, 1 bit each: d234stg_fdiv, div_expadd1_in1_dbl, div_expadd1_in1_sng, div_expadd1_in2_exp_in2_dbl, div_expadd1_in2_exp_in2_sng, d3stg_fdiv, d4stg_fdiv, div_exp1_expadd1, div_exp1_0835, div_exp1_0118, div_exp1_zero, div_exp1_load, div_expadd2_in1_exp_out, d5stg_fdiva, d5stg_fdivd, d5stg_fdivs, d6stg_fdiv, d7stg_fdiv, d7stg_fdivd, div_expadd2_no_decr_inv, div_expadd2_cin, div_exp_out_expadd2, div_exp_out_expadd22_inv, div_exp_out_of, d7stg_to_0_inv, div_exp_out_exp_out, d7stg_rndup_inv, div_exp_out_load

Behaviour:
- Reset (async, arst_l=0):
  - state=S_IDLE, counter=0, dbl/special flags=0.
  - All control outputs 0, except fdiv_clken_l=1 (unless div_start) and the inverted strobes, which follow their S_IDLE decode.
  - Reset mid-operation abandons the operation, with no result.
- States: S_IDLE, S_BIAS, S_SUB2, S_NRM1, S_NRM2, S_ITER, S_REB, S_DEC, S_RND, S_HOLD. Outputs are Moore decodes of state plus registered flags, except d1stg_step and fdiv_clken_l.
- S_IDLE:
  - d1stg_step = div_start.
  - On div_start: capture div_dbl and the special flags, go to S_BIAS.
  - fdiv_clken_l = ~div_start.
  - div_start outside S_IDLE is ignored; the requester must watch div_busy.
- S_BIAS:
  - div_expadd1_in1_dbl/sng per dbl.
  - If special_inf: div_exp1_0835 (inf has priority over zero). Else if special_zero: div_exp1_0118. Else: div_exp1_expadd1.
  - div_exp1_load=1.
  - Next state: S_REB if any special, else S_SUB2.
- S_SUB2: d234stg_fdiv, in2_exp_in2_dbl/sng per dbl, div_exp1_expadd1, load. Next S_NRM1.
- S_NRM1: d234stg_fdiv, d3stg_fdiv, div_exp1_expadd1, load. Next S_NRM2.
- S_NRM2:
  - d234stg_fdiv, d4stg_fdiv, div_exp1_expadd1, load.
  - Counter loads DBL_ITER-1 or SNG_ITER-1. Next S_ITER.
- S_ITER: counter decrements each cycle. Exit to S_REB on the cycle counter==0, so the state lasts exactly DBL_ITER/SNG_ITER cycles. No exponent loads.
- S_REB: d5stg_fdiva=1, d5stg_fdivd=dbl, d5stg_fdivs=~dbl, div_exp_out_expadd2=1, div_exp_out_expadd22_inv=1, div_exp_out_load=1. Next S_DEC.
- S_DEC: d6stg_fdiv, div_expadd2_in1_exp_out, div_expadd2_no_decr_inv=div_q_norm, cin=0, div_exp_out_expadd2=1, div_exp_out_expadd22_inv=1, load. Next S_RND.
- S_RND:
  - d7stg_fdiv, d7stg_fdivd=dbl, div_expadd2_in1_exp_out, div_exp_out_load.
  - If div_ovf: div_exp_out_of=1, d7stg_to_0_inv=~div_rnd_to_0, expadd2/exp_out selects=0 (selects are one-hot).
  - Else: div_exp_out_expadd2=1, div_exp_out_expadd22_inv=1, div_exp_out_exp_out=1, div_expadd2_cin=div_rndup, d7stg_rndup_inv=~div_rndup.
  - Next S_HOLD.
- S_HOLD: div_res_vld=1, no loads. Ack in the same cycle goes to S_IDLE the next cycle. Holds indefinitely without ack.
- fdiv_clken_l = 0 in every non-idle state.
- Latency, start-accept cycle 0 to first valid cycle: double 63, single 34, special 5.
- div_exp1_zero is never asserted by this block (tied 0, reserved).

Decomposition:
- Shared package fpu_div_pkg: state enum encoding, DBL_ITER/SNG_ITER defaults.
- Optional sub-module fpu_div_iter_cnt: loadable down-counter with zero flag.
- Everything else is in one module.

Test Plan:
- Double, no special, div_q_norm=1, div_ovf=0, div_rndup=0:
  - d1stg_step at cycle 0, S_SUB2 at 2, S_ITER cycles 5..59, d5stg_fdivd at 60, div_res_vld at 63.
  - Ack at 65: div_busy=0 at 66.
- Single: d5stg_fdivs=1 at cycle 31; div_res_vld at 34; div_expadd1_in1_sng in cycle 1.
- div_special_inf=1 and div_special_zero=1 together:
  - div_exp1_0835=1 (not 0118) in cycle 1, then S_REB in cycle 2, valid at 5.
- S_RND checks:
  - div_ovf=1, div_rnd_to_0=1: div_exp_out_of=1, d7stg_to_0_inv=0, div_exp_out_expadd2=0.
  - div_ovf=0, div_rndup=1: div_expadd2_cin=1, d7stg_rndup_inv=0.
- div_start pulsed at cycle 10 of a busy op: ignored, with no second d1stg_step. arst_l low at cycle 20: all loads 0 and div_busy=0 immediately; a new start is accepted after release.

Source files
------------

// File: rtl/fpu_div_pkg.sv
// Shared definitions for the divide-pipe exponent sequencer: state encoding
// and default fraction iteration counts.
package fpu_div_pkg;

    localparam int unsigned DBL_ITER_DEF = 55;
    localparam int unsigned SNG_ITER_DEF = 26;
    localparam int unsigned CNT_W_DEF    = 6;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_BIAS = 4'd1,
        S_SUB2 = 4'd2,
        S_NRM1 = 4'd3,
        S_NRM2 = 4'd4,
        S_ITER = 4'd5,
        S_REB  = 4'd6,
        S_DEC  = 4'd7,
        S_RND  = 4'd8,
        S_HOLD = 4'd9
    } state_e;

endpackage

// File: rtl/fpu_div_iter_cnt.sv
// Loadable down-counter timing the fraction iteration window; saturates at zero.
module fpu_div_iter_cnt #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fpu_div_exp_ctl.sv
// Divide-pipe exponent control sequencer: front-end exponent steps, iteration
// wait, back-end rebias/decrement/round, and a valid/ack result handshake.
module fpu_div_exp_ctl
    import fpu_div_pkg::*;
#(
    parameter int unsigned DBL_ITER = DBL_ITER_DEF,
    parameter int unsigned SNG_ITER = SNG_ITER_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic rclk,
    input  logic arst_l,
    input  logic div_start,
    input  logic div_dbl,
    input  logic div_special_inf,
    input  logic div_special_zero,
    input  logic div_q_norm,
    input  logic div_ovf,
    input  logic div_rndup,
    input  logic div_rnd_to_0,
    input  logic div_res_ack,
    output logic div_busy,
    output logic div_res_vld,
    output logic d1stg_step,
    output logic fdiv_clken_l,
    output logic d234stg_fdiv,
    output logic div_expadd1_in1_dbl,
    output logic div_expadd1_in1_sng,
    output logic div_expadd1_in2_exp_in2_dbl,
    output logic div_expadd1_in2_exp_in2_sng,
    output logic d3stg_fdiv,
    output logic d4stg_fdiv,
    output logic div_exp1_expadd1,
    output logic div_exp1_0835,
    output logic div_exp1_0118,
    output logic div_exp1_zero,
    output logic div_exp1_load,
    output logic div_expadd2_in1_exp_out,
    output logic d5stg_fdiva,
    output logic d5stg_fdivd,
    output logic d5stg_fdivs,
    output logic d6stg_fdiv,
    output logic d7stg_fdiv,
    output logic d7stg_fdivd,
    output logic div_expadd2_no_decr_inv,
    output logic div_expadd2_cin,
    output logic div_exp_out_expadd2,
    output logic div_exp_out_expadd22_inv,
    output logic div_exp_out_of,
    output logic d7stg_to_0_inv,
    output logic div_exp_out_exp_out,
    output logic d7stg_rndup_inv,
    output logic div_exp_out_load
);

    localparam logic [CNT_W-1:0] DBL_LD = CNT_W'(DBL_ITER - 1);
    localparam logic [CNT_W-1:0] SNG_LD = CNT_W'(SNG_ITER - 1);

    state_e state_q, state_d;
    logic   dbl_q, dbl_d;
    logic   inf_q, inf_d;
    logic   zero_q, zero_d;
    logic   cnt_load, cnt_dec, cnt_zero;

    fpu_div_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
        .clk_i      (rclk),
        .rst_n_i    (arst_l),
        .load_i     (cnt_load),
        .load_val_i (dbl_q ? DBL_LD : SNG_LD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= S_IDLE;
            dbl_q   <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dbl_q   <= dbl_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dbl_d    = dbl_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        div_busy                    = (state_q != S_IDLE);
        div_res_vld                 = 1'b0;
        d1stg_step                  = 1'b0;
        fdiv_clken_l                = 1'b0;
        d234stg_fdiv                = 1'b0;
        div_expadd1_in1_dbl         = 1'b0;
        div_expadd1_in1_sng         = 1'b0;
        div_expadd1_in2_exp_in2_dbl = 1'b0;
        div_expadd1_in2_exp_in2_sng = 1'b0;
        d3stg_fdiv                  = 1'b0;
        d4stg_fdiv                  = 1'b0;
        div_exp1_expadd1            = 1'b0;
        div_exp1_0835               = 1'b0;
        div_exp1_0118               = 1'b0;
        div_exp1_zero               = 1'b0;
        div_exp1_load               = 1'b0;
        div_expadd2_in1_exp_out     = 1'b0;
        d5stg_fdiva                 = 1'b0;
        d5stg_fdivd                 = 1'b0;
        d5stg_fdivs                 = 1'b0;
        d6stg_fdiv                  = 1'b0;
        d7stg_fdiv                  = 1'b0;
        d7stg_fdivd                 = 1'b0;
        div_expadd2_no_decr_inv     = 1'b1;
        div_expadd2_cin             = 1'b0;
        div_exp_out_expadd2         = 1'b0;
        div_exp_out_expadd22_inv    = 1'b0;
        div_exp_out_of              = 1'b0;
        d7stg_to_0_inv              = 1'b1;
        div_exp_out_exp_out         = 1'b0;
        d7stg_rndup_inv             = 1'b1;
        div_exp_out_load            = 1'b0;

        case (state_q)
            S_IDLE: begin
                fdiv_clken_l = ~div_start;
                // Step strobe is held off while reset is asserted
                d1stg_step   = div_start & arst_l;
                if (div_start) begin
                    dbl_d   = div_dbl;
                    inf_d   = div_special_inf;
                    zero_d  = div_special_zero;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                div_expadd1_in1_dbl = dbl_q;
                div_expadd1_in1_sng = ~dbl_q;
                div_exp1_0835       = inf_q;
                div_exp1_0118       = ~inf_q & zero_q;
                div_exp1_expadd1    = ~inf_q & ~zero_q;
                div_exp1_load       = 1'b1;
                state_d             = (inf_q || zero_q) ? S_REB : S_SUB2;
            end
            S_SUB2: begin
                d234stg_fdiv                = 1'b1;
                div_expadd1_in2_exp_in2_dbl = dbl_q;
                div_expadd1_in2_exp_in2_sng = ~dbl_q;
                div_exp1_expadd1            = 1'b1;
                div_exp1_load               = 1'b1;
                state_d                     = S_NRM1;
            end
            S_NRM1: begin
                d234stg_fdiv     = 1'b1;
                d3stg_fdiv       = 1'b1;
                div_exp1_expadd1 = 1'b1;
                div_exp1_load    = 1'b1;
                state_d          = S_NRM2;
            end
            S_NRM2: begin
                d234stg_fdiv     = 1'b1;
                d4stg_fdiv       = 1'b1;
                div_exp1_expadd1 = 1'b1;
                div_exp1_load    = 1'b1;
                cnt_load         = 1'b1;
                state_d          = S_ITER;
            end
            S_ITER: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = S_REB;
                end
            end
            S_REB: begin
                d5stg_fdiva              = 1'b1;
                d5stg_fdivd              = dbl_q;
                d5stg_fdivs              = ~dbl_q;
                div_exp_out_expadd2      = 1'b1;
                div_exp_out_expadd22_inv = 1'b1;
                div_exp_out_load         = 1'b1;
                state_d                  = S_DEC;
            end
            S_DEC: begin
                d6stg_fdiv               = 1'b1;
                div_expadd2_in1_exp_out  = 1'b1;
                div_expadd2_no_decr_inv  = div_q_norm;
                div_exp_out_expadd2      = 1'b1;
                div_exp_out_expadd22_inv = 1'b1;
                div_exp_out_load         = 1'b1;
                state_d                  = S_RND;
            end
            S_RND: begin
                d7stg_fdiv              = 1'b1;
                d7stg_fdivd             = dbl_q;
                div_expadd2_in1_exp_out = 1'b1;
                div_exp_out_load        = 1'b1;
                if (div_ovf) begin
                    div_exp_out_of = 1'b1;
                    d7stg_to_0_inv = ~div_rnd_to_0;
                end else begin
                    div_exp_out_expadd2      = 1'b1;
                    div_exp_out_expadd22_inv = 1'b1;
                    div_exp_out_exp_out      = 1'b1;
                    div_expadd2_cin          = div_rndup;
                    d7stg_rndup_inv          = ~div_rndup;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                div_res_vld = 1'b1;
                if (div_res_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpu_div_exp_ctl.sv
// Self-checking bench for fpu_div_exp_ctl: latency-based reference model
// compared every cycle, plus directed literal checks of the key timeline points.
module tb_fpu_div_exp_ctl;

    localparam int DBL_N = 55;
    localparam int SNG_N = 26;

    localparam int P_IDLE = 0, P_BIAS = 1, P_SUB2 = 2, P_NRM1 = 3, P_NRM2 = 4;
    localparam int P_ITER = 5, P_REB = 6, P_DEC = 7, P_RND = 8, P_HOLD = 9;

    typedef struct packed {
        logic busy, res_vld, d1stg, clken_l, d234, in1_dbl, in1_sng, in2_dbl;
        logic in2_sng, d3, d4, e1_add, e1_0835, e1_0118, e1_zero, e1_load;
        logic a2_in1, d5a, d5d, d5s, d6, d7, d7d, nodecr_inv;
        logic cin, eo_a2, eo_a22inv, eo_of, to0_inv, eo_eo, rndup_inv, eo_load;
    } outs_t;

    logic rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic arst_l, div_start, div_dbl, div_special_inf, div_special_zero;
    logic div_q_norm, div_ovf, div_rndup, div_rnd_to_0, div_res_ack;
    logic div_busy, div_res_vld, d1stg_step, fdiv_clken_l, d234stg_fdiv;
    logic div_expadd1_in1_dbl, div_expadd1_in1_sng, div_expadd1_in2_exp_in2_dbl;
    logic div_expadd1_in2_exp_in2_sng, d3stg_fdiv, d4stg_fdiv, div_exp1_expadd1;
    logic div_exp1_0835, div_exp1_0118, div_exp1_zero, div_exp1_load;
    logic div_expadd2_in1_exp_out, d5stg_fdiva, d5stg_fdivd, d5stg_fdivs;
    logic d6stg_fdiv, d7stg_fdiv, d7stg_fdivd, div_expadd2_no_decr_inv;
    logic div_expadd2_cin, div_exp_out_expadd2, div_exp_out_expadd22_inv;
    logic div_exp_out_of, d7stg_to_0_inv, div_exp_out_exp_out, d7stg_rndup_inv;
    logic div_exp_out_load;

    fpu_div_exp_ctl #(.DBL_ITER(DBL_N), .SNG_ITER(SNG_N), .CNT_W(6)) dut (
        .rclk(rclk), .arst_l(arst_l), .div_start(div_start), .div_dbl(div_dbl),
        .div_special_inf(div_special_inf), .div_special_zero(div_special_zero),
        .div_q_norm(div_q_norm), .div_ovf(div_ovf), .div_rndup(div_rndup),
        .div_rnd_to_0(div_rnd_to_0), .div_res_ack(div_res_ack),
        .div_busy(div_busy), .div_res_vld(div_res_vld), .d1stg_step(d1stg_step),
        .fdiv_clken_l(fdiv_clken_l), .d234stg_fdiv(d234stg_fdiv),
        .div_expadd1_in1_dbl(div_expadd1_in1_dbl), .div_expadd1_in1_sng(div_expadd1_in1_sng),
        .div_expadd1_in2_exp_in2_dbl(div_expadd1_in2_exp_in2_dbl),
        .div_expadd1_in2_exp_in2_sng(div_expadd1_in2_exp_in2_sng),
        .d3stg_fdiv(d3stg_fdiv), .d4stg_fdiv(d4stg_fdiv),
        .div_exp1_expadd1(div_exp1_expadd1), .div_exp1_0835(div_exp1_0835),
        .div_exp1_0118(div_exp1_0118), .div_exp1_zero(div_exp1_zero),
        .div_exp1_load(div_exp1_load), .div_expadd2_in1_exp_out(div_expadd2_in1_exp_out),
        .d5stg_fdiva(d5stg_fdiva), .d5stg_fdivd(d5stg_fdivd), .d5stg_fdivs(d5stg_fdivs),
        .d6stg_fdiv(d6stg_fdiv), .d7stg_fdiv(d7stg_fdiv), .d7stg_fdivd(d7stg_fdivd),
        .div_expadd2_no_decr_inv(div_expadd2_no_decr_inv), .div_expadd2_cin(div_expadd2_cin),
        .div_exp_out_expadd2(div_exp_out_expadd2),
        .div_exp_out_expadd22_inv(div_exp_out_expadd22_inv),
        .div_exp_out_of(div_exp_out_of), .d7stg_to_0_inv(d7stg_to_0_inv),
        .div_exp_out_exp_out(div_exp_out_exp_out), .d7stg_rndup_inv(d7stg_rndup_inv),
        .div_exp_out_load(div_exp_out_load)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an operation is tracked only as "cycles since accept"
    bit m_busy = 1'b0;
    int m_k = 0;
    bit m_dbl = 1'b0, m_inf = 1'b0, m_zero = 1'b0;

    function automatic int phase_of(input bit busy, input int k, input bit dbl, input bit spec);
        int n;
        if (!busy) return P_IDLE;
        if (k == 1) return P_BIAS;
        if (spec) begin
            if (k == 2) return P_REB;
            if (k == 3) return P_DEC;
            if (k == 4) return P_RND;
            return P_HOLD;
        end
        n = dbl ? DBL_N : SNG_N;
        if (k == 2) return P_SUB2;
        if (k == 3) return P_NRM1;
        if (k == 4) return P_NRM2;
        if (k <= 4 + n) return P_ITER;
        if (k == 5 + n) return P_REB;
        if (k == 6 + n) return P_DEC;
        if (k == 7 + n) return P_RND;
        return P_HOLD;
    endfunction

    function automatic outs_t expect_outs(input int ph, input bit in_rst,
                                          input bit dbl, input bit inf, input bit zero);
        outs_t e;
        e = '0;
        e.nodecr_inv = 1'b1;
        e.to0_inv    = 1'b1;
        e.rndup_inv  = 1'b1;
        e.busy       = (ph != P_IDLE);
        e.clken_l    = (ph == P_IDLE) ? ~div_start : 1'b0;
        case (ph)
            P_IDLE: e.d1stg = div_start & ~in_rst;
            P_BIAS: begin
                e.in1_dbl = dbl; e.in1_sng = ~dbl;
                e.e1_0835 = inf; e.e1_0118 = ~inf & zero; e.e1_add = ~inf & ~zero;
                e.e1_load = 1'b1;
            end
            P_SUB2: begin
                e.d234 = 1'b1; e.in2_dbl = dbl; e.in2_sng = ~dbl;
                e.e1_add = 1'b1; e.e1_load = 1'b1;
            end
            P_NRM1: begin e.d234 = 1'b1; e.d3 = 1'b1; e.e1_add = 1'b1; e.e1_load = 1'b1; end
            P_NRM2: begin e.d234 = 1'b1; e.d4 = 1'b1; e.e1_add = 1'b1; e.e1_load = 1'b1; end
            P_REB: begin
                e.d5a = 1'b1; e.d5d = dbl; e.d5s = ~dbl;
                e.eo_a2 = 1'b1; e.eo_a22inv = 1'b1; e.eo_load = 1'b1;
            end
            P_DEC: begin
                e.d6 = 1'b1; e.a2_in1 = 1'b1; e.nodecr_inv = div_q_norm;
                e.eo_a2 = 1'b1; e.eo_a22inv = 1'b1; e.eo_load = 1'b1;
            end
            P_RND: begin
                e.d7 = 1'b1; e.d7d = dbl; e.a2_in1 = 1'b1; e.eo_load = 1'b1;
                if (div_ovf) begin
                    e.eo_of = 1'b1; e.to0_inv = ~div_rnd_to_0;
                end else begin
                    e.eo_a2 = 1'b1; e.eo_a22inv = 1'b1; e.eo_eo = 1'b1;
                    e.cin = div_rndup; e.rndup_inv = ~div_rndup;
                end
            end
            P_HOLD: e.res_vld = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge rclk) begin
        outs_t exp_o, act_o;
        int ph;
        if (!arst_l) begin
            m_busy = 1'b0; m_k = 0; m_dbl = 1'b0; m_inf = 1'b0; m_zero = 1'b0;
        end
        ph = phase_of(m_busy, m_k, m_dbl, m_inf | m_zero);
        exp_o = expect_outs(ph, !arst_l, m_dbl, m_inf, m_zero);
        act_o = {div_busy, div_res_vld, d1stg_step, fdiv_clken_l, d234stg_fdiv,
                 div_expadd1_in1_dbl, div_expadd1_in1_sng, div_expadd1_in2_exp_in2_dbl,
                 div_expadd1_in2_exp_in2_sng, d3stg_fdiv, d4stg_fdiv, div_exp1_expadd1,
                 div_exp1_0835, div_exp1_0118, div_exp1_zero, div_exp1_load,
                 div_expadd2_in1_exp_out, d5stg_fdiva, d5stg_fdivd, d5stg_fdivs,
                 d6stg_fdiv, d7stg_fdiv, d7stg_fdivd, div_expadd2_no_decr_inv,
                 div_expadd2_cin, div_exp_out_expadd2, div_exp_out_expadd22_inv,
                 div_exp_out_of, d7stg_to_0_inv, div_exp_out_exp_out, d7stg_rndup_inv,
                 div_exp_out_load};
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL model_outs phase=%0d k=%0d: got %b expected %b at %0t",
                     ph, m_k, act_o, exp_o, $time);
        end
        if (arst_l) begin
            if (!m_busy) begin
                if (div_start) begin
                    m_busy = 1'b1; m_k = 1;
                    m_dbl = div_dbl; m_inf = div_special_inf; m_zero = div_special_zero;
                end
            end else if (ph == P_HOLD) begin
                if (div_res_ack) m_busy = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic settle();
        @(negedge rclk);
    endtask

    task automatic quiet_inputs();
        div_start = 1'b0; div_dbl = 1'b0; div_special_inf = 1'b0; div_special_zero = 1'b0;
        div_q_norm = 1'b1; div_ovf = 1'b0; div_rndup = 1'b0; div_rnd_to_0 = 1'b0;
        div_res_ack = 1'b0;
    endtask

    initial begin
        arst_l = 1'b0;
        quiet_inputs();
        settle();
        chk("rst_busy", div_busy, 1'b0);
        chk("rst_clken_l", fdiv_clken_l, 1'b1);
        chk("rst_exp1_load", div_exp1_load, 1'b0);
        repeat (2) tick();
        arst_l = 1'b1;
        tick();

        // Double, no special, ack two cycles after valid, stray start at cycle 10
        div_start = 1'b1; div_dbl = 1'b1;
        settle();
        chk("dbl_c0_d1stg", d1stg_step, 1'b1);
        chk("dbl_c0_clken_l", fdiv_clken_l, 1'b0);
        for (int c = 1; c <= 66; c++) begin
            tick();
            div_start = (c == 10);
            div_res_ack = (c == 65);
            settle();
            case (c)
                1:  chk("dbl_c1_in1_dbl", div_expadd1_in1_dbl, 1'b1);
                2:  chk("dbl_c2_in2_dbl", div_expadd1_in2_exp_in2_dbl, 1'b1);
                5:  chk("dbl_c5_iter_noload", div_exp1_load, 1'b0);
                10: chk("dbl_c10_ignored_start", d1stg_step, 1'b0);
                59: chk("dbl_c59_still_iter", d5stg_fdiva, 1'b0);
                60: chk("dbl_c60_d5d", d5stg_fdivd, 1'b1);
                62: chk("dbl_c62_not_vld", div_res_vld, 1'b0);
                63: chk("dbl_c63_vld", div_res_vld, 1'b1);
                65: chk("dbl_c65_vld_held", div_res_vld, 1'b1);
                66: chk("dbl_c66_idle", div_busy, 1'b0);
                default: ;
            endcase
        end

        // Single with round-up
        tick();
        div_start = 1'b1; div_dbl = 1'b0;
        settle();
        for (int c = 1; c <= 35; c++) begin
            tick();
            div_start = 1'b0;
            div_rndup = (c == 33);
            div_res_ack = (c == 34);
            settle();
            case (c)
                1:  chk("sng_c1_in1_sng", div_expadd1_in1_sng, 1'b1);
                31: chk("sng_c31_d5s", d5stg_fdivs, 1'b1);
                33: begin
                    chk("sng_c33_cin", div_expadd2_cin, 1'b1);
                    chk("sng_c33_rndup_inv", d7stg_rndup_inv, 1'b0);
                    chk("sng_c33_not_vld", div_res_vld, 1'b0);
                end
                34: chk("sng_c34_vld", div_res_vld, 1'b1);
                35: chk("sng_c35_idle", div_busy, 1'b0);
                default: ;
            endcase
        end

        // Both specials: infinity wins; overflow toward max-finite in round step
        tick();
        div_start = 1'b1; div_dbl = 1'b1; div_special_inf = 1'b1; div_special_zero = 1'b1;
        settle();
        for (int c = 1; c <= 6; c++) begin
            tick();
            div_start = 1'b0; div_special_inf = 1'b0; div_special_zero = 1'b0;
            div_ovf = (c == 4);
            div_rnd_to_0 = (c == 4);
            div_res_ack = (c == 5);
            settle();
            case (c)
                1: begin
                    chk("spc_c1_0835", div_exp1_0835, 1'b1);
                    chk("spc_c1_0118", div_exp1_0118, 1'b0);
                end
                2: chk("spc_c2_reb", d5stg_fdiva, 1'b1);
                4: begin
                    chk("spc_c4_of", div_exp_out_of, 1'b1);
                    chk("spc_c4_to0_inv", d7stg_to_0_inv, 1'b0);
                    chk("spc_c4_expadd2", div_exp_out_expadd2, 1'b0);
                end
                5: chk("spc_c5_vld", div_res_vld, 1'b1);
                6: chk("spc_c6_idle", div_busy, 1'b0);
                default: ;
            endcase
        end

        // Reset mid-operation, then a fresh start
        tick();
        div_start = 1'b1; div_dbl = 1'b1;
        settle();
        for (int c = 1; c <= 22; c++) begin
            tick();
            div_start = (c == 21);
            div_dbl = (c == 21) ? 1'b0 : 1'b1;
            arst_l = (c != 20);
            settle();
            case (c)
                20: begin
                    chk("rst20_busy", div_busy, 1'b0);
                    chk("rst20_exp1_load", div_exp1_load, 1'b0);
                    chk("rst20_eo_load", div_exp_out_load, 1'b0);
                end
                21: chk("rst21_restart", d1stg_step, 1'b1);
                22: chk("rst22_in1_sng", div_expadd1_in1_sng, 1'b1);
                default: ;
            endcase
        end

        // Randomized traffic; the per-cycle model compare covers it
        for (int i = 0; i < 4000; i++) begin
            tick();
            arst_l           = ($urandom_range(0, 599) != 0);
            div_start        = ($urandom_range(0, 3) == 0);
            div_dbl          = ($urandom_range(0, 2) == 0);
            div_special_inf  = ($urandom_range(0, 5) == 0);
            div_special_zero = ($urandom_range(0, 5) == 0);
            div_q_norm       = $urandom_range(0, 1) != 0;
            div_ovf          = $urandom_range(0, 1) != 0;
            div_rndup        = $urandom_range(0, 1) != 0;
            div_rnd_to_0     = $urandom_range(0, 1) != 0;
            div_res_ack      = ($urandom_range(0, 2) == 0);
        end

        tick();
        arst_l = 1'b1;
        quiet_inputs();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
